// File: rtl/vga_cmd_port.sv
// VGA-side command port: turns cs_h/ready_h handshaked commands into VRAM
// write/read cycles and owns the text cursor position and visibility.
module vga_cmd_port #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter int         ADR_W     = 11,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_cmd,
    input  logic [ADR_W-1:0] i_cur_adr,
    input  logic [7:0]       i_port,
    output logic [7:0]       o_port,
    input  logic             i_cs_h,
    input  logic             i_rl_wh,
    output logic             o_ready_h,
    output logic [ADR_W-1:0] o_vram_addr,
    output logic [7:0]       o_vram_data,
    output logic             o_vram_we,
    input  logic [7:0]       i_vram_rdata,
    output logic [ADR_W-1:0] o_cursor_addr,
    output logic             o_cursor_en
);

    localparam int               CELLS     = COLS * ROWS;
    localparam logic [ADR_W:0]   CELLS_EXT = (ADR_W+1)'(CELLS);
    localparam logic [ADR_W-1:0] LAST_CELL = ADR_W'(CELLS - 1);
    localparam logic [ADR_W-1:0] ZERO_A    = {ADR_W{1'b0}};
    localparam logic [ADR_W-1:0] ONE_A     = ADR_W'(32'd1);

    localparam logic [7:0] CMD_SET   = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_CLEAR = 8'h04;
    localparam logic [7:0] CMD_ON    = 8'h05;
    localparam logic [7:0] CMD_OFF   = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CLEAR   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_r,     state_s;
    logic             ready_r,     ready_s;
    logic [7:0]       cmd_r,       cmd_s;
    logic             rl_wh_r,     rl_wh_s;
    logic [ADR_W-1:0] cur_adr_r,   cur_adr_s;
    logic [ADR_W-1:0] cursor_r,    cursor_s;
    logic             cursor_en_r, cursor_en_s;
    logic [7:0]       port_r,      port_s;
    logic [ADR_W-1:0] vram_addr_r, vram_addr_s;
    logic [7:0]       vram_data_r, vram_data_s;
    logic             vram_we_r,   vram_we_s;

    function automatic logic [ADR_W-1:0] next_cell(input logic [ADR_W-1:0] a);
        if (a == LAST_CELL) begin
            return ZERO_A;
        end else begin
            return a + ONE_A;
        end
    endfunction

    function automatic logic in_range(input logic [ADR_W-1:0] a);
        return ({1'b0, a} < CELLS_EXT);
    endfunction

    // Next-state and next-output decode; VRAM strobes are registered so they
    // are prepared one state ahead (the accept edge sets up the EXEC-cycle write).
    always_comb begin
        state_s     = state_r;
        ready_s     = 1'b0;
        cmd_s       = cmd_r;
        rl_wh_s     = rl_wh_r;
        cur_adr_s   = cur_adr_r;
        cursor_s    = cursor_r;
        cursor_en_s = cursor_en_r;
        port_s      = port_r;
        vram_addr_s = vram_addr_r;
        vram_data_s = vram_data_r;
        vram_we_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ready_r && i_cs_h) begin
                    state_s   = ST_EXEC;
                    cmd_s     = i_cmd;
                    rl_wh_s   = i_rl_wh;
                    cur_adr_s = i_cur_adr;
                    if (i_cmd == CMD_WRITE && !i_rl_wh) begin
                        vram_addr_s = cursor_r;
                        vram_data_s = i_port;
                        vram_we_s   = 1'b1;
                    end else if (i_cmd == CMD_READ && i_rl_wh) begin
                        vram_addr_s = cursor_r;
                    end else begin
                        vram_addr_s = vram_addr_r;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            ST_EXEC: begin
                state_s = ST_DONE;
                case (cmd_r)
                    CMD_SET: begin
                        cursor_s = in_range(cur_adr_r) ? cur_adr_r : ZERO_A;
                    end
                    CMD_WRITE: begin
                        if (!rl_wh_r) begin
                            cursor_s = next_cell(cursor_r);
                        end else begin
                            cursor_s = cursor_r;
                        end
                    end
                    CMD_READ: begin
                        if (rl_wh_r) begin
                            state_s = ST_RD_WAIT;
                        end else begin
                            state_s = ST_DONE;
                        end
                    end
                    CMD_CLEAR: begin
                        state_s     = ST_CLEAR;
                        vram_addr_s = ZERO_A;
                        vram_data_s = FILL_CHAR;
                        vram_we_s   = 1'b1;
                    end
                    CMD_ON:  cursor_en_s = 1'b1;
                    CMD_OFF: cursor_en_s = 1'b0;
                    default: state_s = ST_DONE;
                endcase
            end
            ST_RD_WAIT: begin
                port_s  = i_vram_rdata;
                state_s = ST_DONE;
            end
            ST_CLEAR: begin
                if (vram_addr_r == LAST_CELL) begin
                    state_s  = ST_DONE;
                    cursor_s = ZERO_A;
                end else begin
                    vram_addr_s = vram_addr_r + ONE_A;
                    vram_we_s   = 1'b1;
                end
            end
            ST_DONE: begin
                ready_s = 1'b1;
                if (!i_cs_h) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and output registers; async reset also aborts a CLEAR in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            cmd_r       <= 8'h00;
            rl_wh_r     <= 1'b0;
            cur_adr_r   <= ZERO_A;
            cursor_r    <= ZERO_A;
            cursor_en_r <= 1'b1;
            port_r      <= 8'h00;
            vram_addr_r <= ZERO_A;
            vram_data_r <= 8'h00;
            vram_we_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ready_r     <= ready_s;
            cmd_r       <= cmd_s;
            rl_wh_r     <= rl_wh_s;
            cur_adr_r   <= cur_adr_s;
            cursor_r    <= cursor_s;
            cursor_en_r <= cursor_en_s;
            port_r      <= port_s;
            vram_addr_r <= vram_addr_s;
            vram_data_r <= vram_data_s;
            vram_we_r   <= vram_we_s;
        end
    end

    assign o_ready_h     = ready_r;
    assign o_port        = port_r;
    assign o_vram_addr   = vram_addr_r;
    assign o_vram_data   = vram_data_r;
    assign o_vram_we     = vram_we_r;
    assign o_cursor_addr = cursor_r;
    assign o_cursor_en   = cursor_en_r;

endmodule

// File: tb/tb_vga_cmd_port.sv
// Randomised self-checking bench for vga_cmd_port with a synchronous VRAM
// model and a command-level reference model of cursor, enable and screen.
module tb_vga_cmd_port;

    localparam int CELLS = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [10:0] cur_adr = 11'd0;
    logic [7:0]  port_in = 8'h00;
    logic [7:0]  port_out;
    logic        cs = 1'b0;
    logic        rl_wh = 1'b0;
    logic        ready;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic [10:0] cursor_addr;
    logic        cursor_en;

    int checks = 0;
    int errors = 0;

    vga_cmd_port dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd(cmd), .i_cur_adr(cur_adr),
        .i_port(port_in), .o_port(port_out), .i_cs_h(cs), .i_rl_wh(rl_wh),
        .o_ready_h(ready), .o_vram_addr(vram_addr), .o_vram_data(vram_data),
        .o_vram_we(vram_we), .i_vram_rdata(vram_rdata),
        .o_cursor_addr(cursor_addr), .o_cursor_en(cursor_en)
    );

    always #20 clk = ~clk;

    // Synchronous VRAM with a write log and a bench-side preload port.
    logic [7:0]  vram [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_addr = 11'd0;
    logic [7:0]  pre_data = 8'h00;
    int          we_cnt = 0;
    int          log_addr [$];
    logic [7:0]  log_data [$];

    always @(posedge clk) begin
        if (vram_we) begin
            vram[vram_addr] <= vram_data;
            we_cnt = we_cnt + 1;
            log_addr.push_back(int'(vram_addr));
            log_data.push_back(vram_data);
        end else if (pre_we) begin
            vram[pre_addr] <= pre_data;
        end
        vram_rdata <= vram[vram_addr];
    end

    // Reference model: command semantics, expected latency and write count.
    logic [10:0] m_cursor;
    logic        m_en;
    logic [7:0]  m_port;
    logic [7:0]  m_vram [0:2047];
    int          m_lat;
    int          m_writes;

    task automatic model_cmd(input logic [7:0] c, input logic [10:0] a,
                             input logic [7:0] d, input logic rw);
        m_lat = 2;
        m_writes = 0;
        if (c == 8'h01) begin
            m_cursor = (int'(a) >= CELLS) ? 11'd0 : a;
        end else if (c == 8'h02 && !rw) begin
            m_vram[m_cursor] = d;
            m_cursor = 11'((int'(m_cursor) + 1) % CELLS);
            m_writes = 1;
        end else if (c == 8'h03 && rw) begin
            m_port = m_vram[m_cursor];
            m_lat = 3;
        end else if (c == 8'h04) begin
            for (int i = 0; i < CELLS; i++) m_vram[i] = 8'h20;
            m_cursor = 11'd0;
            m_lat = CELLS + 2;
            m_writes = CELLS;
        end else if (c == 8'h05) begin
            m_en = 1'b1;
        end else if (c == 8'h06) begin
            m_en = 1'b0;
        end
    endtask

    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        m_vram[a] = d;
    endtask

    // One full handshake; inputs are scrambled while busy, cs optionally dropped early.
    task automatic do_cmd(input logic [7:0] c, input logic [10:0] a, input logic [7:0] d,
                          input logic rw, input bit early, output int lat, output int nwr);
        int  w0;
        bit  got;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept got=%b want=1", ready);
        end
        cmd = c; cur_adr = a; port_in = d; rl_wh = rw; cs = 1'b1;
        w0 = we_cnt;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept got=%b want=0", ready);
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            cmd = 8'($urandom); cur_adr = 11'($urandom); port_in = 8'($urandom);
            rl_wh = 1'($urandom);
            if (early) cs = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (ready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ready_timeout cmd=%h waited=%0d cycles", c, lat);
        end
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk); #1;
        nwr = we_cnt - w0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || vram_we !== 1'b0 || cursor_en !== 1'b1 || port_out !== 8'h00 ||
            cursor_addr !== 11'd0 || vram_addr !== 11'd0 || vram_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_values rdy=%b we=%b en=%b port=%h cur=%0d got, want 0 0 1 00 0",
                     ready, vram_we, cursor_en, port_out, cursor_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got=%b want=0", ready);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || cursor_addr !== 11'd0 || cursor_en !== 1'b1 || vram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b cur=%0d en=%b we=%b want 1 0 1 0",
                     ready, cursor_addr, cursor_en, vram_we);
        end
        m_cursor = 11'd0; m_en = 1'b1; m_port = 8'h00;
    endtask

    task automatic test_wrap;
        int lat, nwr, w0;
        w0 = we_cnt;
        do_cmd(8'h01, 11'd1998, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h01, 11'd1998, 8'h00, 1'b0);
        checks++;
        if (lat != m_lat || cursor_addr !== m_cursor) begin
            errors++;
            $display("FAIL set_cursor lat=%0d cur=%0d want lat=%0d cur=%0d", lat, cursor_addr, m_lat, m_cursor);
        end
        do_cmd(8'h02, 11'd0, 8'h41, 1'b0, 1'b0, lat, nwr); model_cmd(8'h02, 11'd0, 8'h41, 1'b0);
        checks++;
        if (lat != m_lat || nwr != 1) begin
            errors++;
            $display("FAIL write_a lat=%0d writes=%0d want lat=%0d writes=1", lat, nwr, m_lat);
        end
        do_cmd(8'h02, 11'd0, 8'h42, 1'b0, 1'b0, lat, nwr); model_cmd(8'h02, 11'd0, 8'h42, 1'b0);
        checks++;
        if (vram[1998] !== 8'h41 || vram[1999] !== 8'h42 || cursor_addr !== 11'd0 || we_cnt - w0 != 2) begin
            errors++;
            $display("FAIL wrap_write v1998=%h v1999=%h cur=%0d we=%0d want 41 42 0 2",
                     vram[1998], vram[1999], cursor_addr, we_cnt - w0);
        end
    endtask

    task automatic test_read;
        int lat, nwr;
        preload(11'd5, 8'h7E);
        do_cmd(8'h01, 11'd5, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h01, 11'd5, 8'h00, 1'b0);
        do_cmd(8'h03, 11'd0, 8'h00, 1'b1, 1'b0, lat, nwr); model_cmd(8'h03, 11'd0, 8'h00, 1'b1);
        checks++;
        if (port_out !== 8'h7E || lat != 3 || cursor_addr !== 11'd5 || nwr != 0) begin
            errors++;
            $display("FAIL read_char port=%h lat=%0d cur=%0d wr=%0d want 7e 3 5 0",
                     port_out, lat, cursor_addr, nwr);
        end
    endtask

    task automatic test_clear_abort;
        int lat, nwr, w0, l0, bad;
        preload(11'd99, 8'h5A);
        preload(11'd100, 8'h5A);
        preload(11'd101, 8'h5A);
        @(negedge clk);
        cmd = 8'h04; rl_wh = 1'b0; cs = 1'b1;
        w0 = we_cnt;
        for (int i = 0; i < 300 && (we_cnt - w0) < 100; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (vram_we !== 1'b0 || ready !== 1'b0 || cursor_addr !== 11'd0 || vram_addr !== 11'd0 ||
            cursor_en !== 1'b1 || we_cnt - w0 != 100) begin
            errors++;
            $display("FAIL clear_abort we=%b rdy=%b cur=%0d adr=%0d writes=%0d want 0 0 0 0 100",
                     vram_we, ready, cursor_addr, vram_addr, we_cnt - w0);
        end
        cs = 1'b0;
        for (int i = 0; i < 100; i++) m_vram[i] = 8'h20;
        m_cursor = 11'd0; m_en = 1'b1; m_port = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 100; i++) if (vram[i] !== 8'h20) bad++;
        checks++;
        if (bad != 0 || vram[100] !== 8'h5A || vram[101] !== 8'h5A || ready !== 1'b1) begin
            errors++;
            $display("FAIL partial_clear bad=%0d v100=%h v101=%h rdy=%b want 0 5a 5a 1",
                     bad, vram[100], vram[101], ready);
        end
        l0 = log_addr.size();
        do_cmd(8'h04, 11'd7, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h04, 11'd7, 8'h00, 1'b0);
        bad = 0;
        for (int i = 0; i < CELLS; i++)
            if (log_addr[l0 + i] != i || log_data[l0 + i] !== 8'h20) bad++;
        checks++;
        if (lat != m_lat || nwr != CELLS || bad != 0 || cursor_addr !== 11'd0) begin
            errors++;
            $display("FAIL full_clear lat=%0d writes=%0d badlog=%0d cur=%0d want %0d %0d 0 0",
                     lat, nwr, bad, cursor_addr, m_lat, CELLS);
        end
    endtask

    task automatic test_mismatch;
        int lat, nwr;
        do_cmd(8'h01, 11'd10, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h01, 11'd10, 8'h00, 1'b0);
        do_cmd(8'h02, 11'd0, 8'h33, 1'b1, 1'b0, lat, nwr); model_cmd(8'h02, 11'd0, 8'h33, 1'b1);
        checks++;
        if (lat != 2 || nwr != 0 || cursor_addr !== 11'd10) begin
            errors++;
            $display("FAIL write_rlwh1 lat=%0d writes=%0d cur=%0d want 2 0 10", lat, nwr, cursor_addr);
        end
        do_cmd(8'hFF, 11'd3, 8'h44, 1'b0, 1'b1, lat, nwr); model_cmd(8'hFF, 11'd3, 8'h44, 1'b0);
        checks++;
        if (lat != 2 || nwr != 0 || cursor_addr !== 11'd10 || cursor_en !== 1'b1) begin
            errors++;
            $display("FAIL unknown_cmd lat=%0d writes=%0d cur=%0d en=%b want 2 0 10 1",
                     lat, nwr, cursor_addr, cursor_en);
        end
    endtask

    task automatic test_hold_cs;
        int lat, nwr, w0;
        bit got;
        do_cmd(8'h01, 11'd20, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h01, 11'd20, 8'h00, 1'b0);
        @(negedge clk);
        cmd = 8'h02; port_in = 8'h55; rl_wh = 1'b0; cs = 1'b1;
        w0 = we_cnt;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (i > 0 && ready === 1'b1) got = 1'b1;
        end
        model_cmd(8'h02, 11'd0, 8'h55, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL hold_cs_ready cycle=%0d got=%b want=1", i, ready);
            end
        end
        checks++;
        if (!got || we_cnt - w0 != 1) begin
            errors++;
            $display("FAIL hold_cs_single done=%b writes=%0d want 1 1", got, we_cnt - w0);
        end
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        cs = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reaccept got_ready=%b want=0", ready);
        end
        model_cmd(8'h02, 11'd0, 8'h55, 1'b0);
        for (int i = 0; i < 10 && ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk); #1;
        do_cmd(8'h06, 11'd0, 8'h00, 1'b0, 1'b0, lat, nwr); model_cmd(8'h06, 11'd0, 8'h00, 1'b0);
        checks++;
        if (cursor_en !== 1'b0 || cursor_addr !== 11'd22 || vram[20] !== 8'h55 || vram[21] !== 8'h55) begin
            errors++;
            $display("FAIL cursor_off en=%b cur=%0d v20=%h v21=%h want 0 22 55 55",
                     cursor_en, cursor_addr, vram[20], vram[21]);
        end
    endtask

    task automatic test_random;
        int lat, nwr, op, bad;
        logic [7:0]  c;
        logic [10:0] a;
        logic [7:0]  d;
        logic        rw;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            a = 11'($urandom_range(0, 2047));
            d = 8'($urandom);
            rw = 1'($urandom_range(0, 1));
            case (op)
                0, 1:    c = 8'h01;
                2, 3, 9: begin c = 8'h02; rw = ($urandom_range(0, 5) == 0); end
                4, 5:    begin c = 8'h03; rw = ($urandom_range(0, 5) != 0); end
                6:       c = 8'h05;
                7:       c = 8'h06;
                default: c = 8'($urandom_range(7, 255));
            endcase
            do_cmd(c, a, d, rw, 1'($urandom_range(0, 1)), lat, nwr);
            model_cmd(c, a, d, rw);
            checks++;
            if (lat != m_lat || nwr != m_writes || cursor_addr !== m_cursor ||
                cursor_en !== m_en || port_out !== m_port) begin
                errors++;
                $display("FAIL random_%0d cmd=%h rw=%b lat=%0d wr=%0d cur=%0d en=%b port=%h want %0d %0d %0d %b %h",
                         n, c, rw, lat, nwr, cursor_addr, cursor_en, port_out,
                         m_lat, m_writes, m_cursor, m_en, m_port);
            end
        end
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (vram[i] !== m_vram[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL vram_contents differing_cells=%0d want 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) m_vram[i] = 8'bxxxx_xxxx;
        repeat (3) @(negedge clk);
        test_reset();
        test_wrap();
        test_read();
        test_clear_abort();
        test_mismatch();
        test_hold_cs();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
